// File: rtl/gpio_in_debounce.sv
// Per-pin synchroniser and debouncer for the GPIO read port. Each settled edge
// is latched in sticky rise/fall flags, and any set flag raises the single IRQ line.
module gpio_in_debounce #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_CYCLES   = 50000,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic [WIDTH-1:0] PIN_IN,
   input  logic [WIDTH-1:0] EDGE_CLR,
   output logic [WIDTH-1:0] IO_OUT,
   output logic [WIDTH-1:0] RISE_FLAG,
   output logic [WIDTH-1:0] FALL_FLAG,
   output logic             IRQ
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_COUNT  = 1'b1
   } state_t;

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_accept;

   // Metastability chain; only its last stage feeds the debouncers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            r_sync[s] <= '0;
         end
      end else begin
         r_sync[0] <= PIN_IN;
         for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

   for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_mis;
      logic             w_acc;

      assign w_mis = w_sync[g] ^ IO_OUT[g];

      always_ff @(posedge HCLK) begin
         if (HRESET) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
         end
      end

      // A new level is taken only after DB_CYCLES consecutive mismatching cycles.
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_acc       = 1'b0;
         case (r_state)
            ST_STABLE: begin
               w_cnt_nxt = '0;
               if (w_mis) begin
                  if (DB_CYCLES == 1) begin
                     w_acc = 1'b1;
                  end else begin
                     w_cnt_nxt   = CNT_W'(1);
                     w_state_nxt = ST_COUNT;
                  end
               end
            end
            ST_COUNT: begin
               if (!w_mis) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_STABLE;
               end else if (r_cnt == CNT_LAST) begin
                  w_acc       = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_STABLE;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_STABLE;
            end
         endcase
      end

      assign w_accept[g] = w_acc;
   end

   // An accepted bit always differs from IO_OUT, so toggling lands on the new level.
   // A set in the same cycle as a clear takes priority.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         IO_OUT    <= '0;
         RISE_FLAG <= '0;
         FALL_FLAG <= '0;
      end else begin
         IO_OUT    <= IO_OUT ^ w_accept;
         RISE_FLAG <= (RISE_FLAG & ~EDGE_CLR) | (w_accept & w_sync);
         FALL_FLAG <= (FALL_FLAG & ~EDGE_CLR) | (w_accept & ~w_sync);
      end
   end

   assign IRQ = |(RISE_FLAG | FALL_FLAG);

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: directed scenarios with fixed expectations, plus
// a randomized run compared every cycle against a run-length reference model.
module tb_gpio_in_debounce;

   localparam int unsigned W    = 8;
   localparam int unsigned SYNC = 2;
   localparam int unsigned DB   = 4;

   logic         HCLK = 1'b0;
   logic         HRESET;
   logic [W-1:0] PIN_IN;
   logic [W-1:0] EDGE_CLR;
   logic [W-1:0] IO_OUT;
   logic [W-1:0] RISE_FLAG;
   logic [W-1:0] FALL_FLAG;
   logic         IRQ;

   int n_checks = 0;
   int n_errors = 0;

   gpio_in_debounce #(
      .WIDTH(W), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .CNT_W(16)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .PIN_IN(PIN_IN), .EDGE_CLR(EDGE_CLR),
      .IO_OUT(IO_OUT), .RISE_FLAG(RISE_FLAG), .FALL_FLAG(FALL_FLAG), .IRQ(IRQ)
   );

   always #5 HCLK = ~HCLK;

   // Reference: pin delayed SYNC edges; a bit flips once its sampled level has
   // disagreed with the output for DB consecutive edges.
   logic [W-1:0] m_hist [SYNC];
   logic [W-1:0] m_out, m_rise, m_fall, m_s, m_acc;
   int           m_run [W];

   always @(posedge HCLK) begin
      if (HRESET) begin
         for (int s = 0; s < int'(SYNC); s++) m_hist[s] = '0;
         for (int i = 0; i < int'(W); i++) m_run[i] = 0;
         m_out  = '0;
         m_rise = '0;
         m_fall = '0;
      end else begin
         m_s = m_hist[SYNC-1];
         for (int s = int'(SYNC) - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
         m_hist[0] = PIN_IN;
         m_acc = '0;
         for (int i = 0; i < int'(W); i++) begin
            if (m_s[i] != m_out[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] >= int'(DB)) begin
                  m_acc[i] = 1'b1;
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_rise = (m_rise & ~EDGE_CLR) | (m_acc & m_s);
         m_fall = (m_fall & ~EDGE_CLR) | (m_acc & ~m_s);
         m_out  = m_out ^ m_acc;
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      HRESET   = 1'b1;
      PIN_IN   = '0;
      EDGE_CLR = '0;
      tick();
      tick();
      HRESET = 1'b0;
   endtask

   task automatic test_reset();
      HRESET   = 1'b1;
      PIN_IN   = 8'hFF;
      EDGE_CLR = '0;
      repeat (3) tick();
      n_checks++;
      if (IO_OUT !== 8'h00 || RISE_FLAG !== 8'h00 || FALL_FLAG !== 8'h00 || IRQ !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_hold: io=%h rise=%h fall=%h irq=%b expected 00 00 00 0",
                  IO_OUT, RISE_FLAG, FALL_FLAG, IRQ);
      end
      HRESET = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 5) begin
            n_checks++;
            if (IO_OUT !== 8'h00) begin
               n_errors++;
               $display("FAIL reset_early: io=%h expected 00 at edge 5", IO_OUT);
            end
         end
      end
      n_checks++;
      if (IO_OUT !== 8'hFF || RISE_FLAG !== 8'hFF || FALL_FLAG !== 8'h00 || IRQ !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release: io=%h rise=%h fall=%h irq=%b expected ff ff 00 1",
                  IO_OUT, RISE_FLAG, FALL_FLAG, IRQ);
      end
   endtask

   task automatic test_step();
      do_reset();
      PIN_IN = 8'h01;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 5) begin
            n_checks++;
            if (IO_OUT !== 8'h00) begin
               n_errors++;
               $display("FAIL step_edge5: io=%h expected 00", IO_OUT);
            end
         end
      end
      n_checks++;
      if (IO_OUT !== 8'h01 || RISE_FLAG !== 8'h01 || FALL_FLAG !== 8'h00) begin
         n_errors++;
         $display("FAIL step_edge6: io=%h rise=%h fall=%h expected 01 01 00",
                  IO_OUT, RISE_FLAG, FALL_FLAG);
      end
   endtask

   task automatic test_glitch();
      logic seen;
      do_reset();
      PIN_IN = 8'h08;
      repeat (3) tick();
      PIN_IN = 8'h00;
      seen = 1'b0;
      repeat (10) begin
         tick();
         if (IO_OUT[3]) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0 || RISE_FLAG !== 8'h00 || FALL_FLAG !== 8'h00) begin
         n_errors++;
         $display("FAIL glitch_short: seen=%b rise=%h fall=%h expected 0 00 00",
                  seen, RISE_FLAG, FALL_FLAG);
      end
      PIN_IN = 8'h08;
      repeat (4) tick();
      PIN_IN = 8'h00;
      seen = 1'b0;
      repeat (12) begin
         tick();
         if (IO_OUT[3]) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b1 || RISE_FLAG !== 8'h08 || FALL_FLAG !== 8'h08 || IO_OUT !== 8'h00) begin
         n_errors++;
         $display("FAIL glitch_exact: seen=%b rise=%h fall=%h io=%h expected 1 08 08 00",
                  seen, RISE_FLAG, FALL_FLAG, IO_OUT);
      end
   endtask

   task automatic test_clear();
      do_reset();
      PIN_IN = 8'h09;
      repeat (6) tick();
      n_checks++;
      if (RISE_FLAG !== 8'h09) begin
         n_errors++;
         $display("FAIL clear_setup: rise=%h expected 09", RISE_FLAG);
      end
      EDGE_CLR = 8'h01;
      tick();
      EDGE_CLR = 8'h00;
      n_checks++;
      if (RISE_FLAG !== 8'h08 || IRQ !== 1'b1) begin
         n_errors++;
         $display("FAIL clear_bit0: rise=%h irq=%b expected 08 1", RISE_FLAG, IRQ);
      end
      PIN_IN = 8'h01;
      repeat (6) tick();
      n_checks++;
      if (FALL_FLAG !== 8'h08 || IO_OUT !== 8'h01 || RISE_FLAG !== 8'h08) begin
         n_errors++;
         $display("FAIL clear_fall3: fall=%h io=%h rise=%h expected 08 01 08",
                  FALL_FLAG, IO_OUT, RISE_FLAG);
      end
      PIN_IN = 8'h09;
      repeat (5) tick();
      EDGE_CLR = 8'h08;
      tick();
      EDGE_CLR = 8'h00;
      n_checks++;
      if (IO_OUT !== 8'h09 || RISE_FLAG !== 8'h08 || FALL_FLAG !== 8'h00) begin
         n_errors++;
         $display("FAIL clear_set_wins: io=%h rise=%h fall=%h expected 09 08 00",
                  IO_OUT, RISE_FLAG, FALL_FLAG);
      end
   endtask

   task automatic test_bounce();
      int   rises;
      int   rise_k;
      logic prev;
      do_reset();
      rises  = 0;
      rise_k = -1;
      prev   = IO_OUT[5];
      for (int c = 0; c < 40; c++) begin
         PIN_IN[5] = ((c / 2) % 2) == 0;
         tick();
         if (IO_OUT[5] && !prev) rises++;
         prev = IO_OUT[5];
      end
      PIN_IN[5] = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (IO_OUT[5] && !prev) begin
            rises++;
            rise_k = k;
         end
         prev = IO_OUT[5];
      end
      n_checks++;
      if (rises != 1 || rise_k != 6 || IO_OUT !== 8'h20) begin
         n_errors++;
         $display("FAIL bounce: rises=%0d at_edge=%0d io=%h expected 1 6 20",
                  rises, rise_k, IO_OUT);
      end
   endtask

   task automatic test_reset_midcount();
      do_reset();
      PIN_IN = 8'h01;
      repeat (3) tick();
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      n_checks++;
      if (IO_OUT !== 8'h00 || RISE_FLAG !== 8'h00 || FALL_FLAG !== 8'h00) begin
         n_errors++;
         $display("FAIL midreset_hold: io=%h rise=%h fall=%h expected 00 00 00",
                  IO_OUT, RISE_FLAG, FALL_FLAG);
      end
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 5) begin
            n_checks++;
            if (IO_OUT !== 8'h00) begin
               n_errors++;
               $display("FAIL midreset_edge5: io=%h expected 00", IO_OUT);
            end
         end
      end
      n_checks++;
      if (IO_OUT !== 8'h01 || RISE_FLAG !== 8'h01) begin
         n_errors++;
         $display("FAIL midreset_edge6: io=%h rise=%h expected 01 01", IO_OUT, RISE_FLAG);
      end
   endtask

   task automatic test_random();
      int hold [W];
      do_reset();
      for (int i = 0; i < int'(W); i++) hold[i] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < int'(W); i++) begin
            if (hold[i] == 0) begin
               PIN_IN[i] = 1'($urandom);
               hold[i]   = int'($urandom_range(1, 8));
            end
            hold[i]--;
         end
         EDGE_CLR = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
         HRESET   = ($urandom_range(0, 199) == 0);
         tick();
         n_checks++;
         if (IO_OUT !== m_out || RISE_FLAG !== m_rise || FALL_FLAG !== m_fall ||
             IRQ !== |(m_rise | m_fall)) begin
            n_errors++;
            $display("FAIL random_c%0d: io=%h rise=%h fall=%h irq=%b expected %h %h %h %b",
                     c, IO_OUT, RISE_FLAG, FALL_FLAG, IRQ, m_out, m_rise, m_fall,
                     |(m_rise | m_fall));
         end
      end
      HRESET   = 1'b0;
      EDGE_CLR = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET   = 1'b1;
      PIN_IN   = '0;
      EDGE_CLR = '0;
      test_reset();
      test_step();
      test_glitch();
      test_clear();
      test_bounce();
      test_reset_midcount();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
